// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF synchroniser, 3-sample majority vote per bit, parity/framing checks.
// Word presented with a 1-cycle data_valid at t0 + (F-1)*BPS_CNT + H + 2; no backpressure, consumer must accept every strobe.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW      = $clog2(BPS_CNT);
    localparam int H       = BPS_CNT / 2;

    localparam logic [CW-1:0] CNT_MAX = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] SAMP0   = CW'(H - 1);
    localparam logic [CW-1:0] SAMP1   = CW'(H);
    localparam logic [CW-1:0] SAMP2   = CW'(H + 1);
    localparam logic [3:0]    LAST_DB = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_SB = 4'(STOP_BITS - 1);
    localparam logic          ODD     = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   pe_q, pe_d;
    logic                   fe_q, fe_d;

    logic fall_edge;
    logic decide;
    logic vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign fall_edge = rxd_prev_q & ~rxd_sync_q;
    assign decide    = (cnt_q == SAMP2);
    // Third sample is the live synced value, so the vote resolves in the H+1 cycle itself.
    assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) | (samp_q[1] & rxd_sync_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        pe_d      = pe_q;
        fe_d      = fe_q;

        if (state_q == S_IDLE) begin
            cnt_d = fall_edge ? CW'(1) : '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (cnt_q == SAMP0) samp_d[0] = rxd_sync_q;
        if (cnt_q == SAMP1) samp_d[1] = rxd_sync_q;

        case (state_q)
            S_IDLE: begin
                if (fall_edge) begin
                    state_d   = S_START;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            S_START: begin
                if (decide) begin
                    state_d = vote ? S_IDLE : S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DB) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    par_err_d = ((^shift_q) ^ vote) != ODD;
                    bit_d     = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (!vote) frm_err_d = 1'b1;
                    if (bit_q == LAST_SB) begin
                        // Leave at mid-stop so a start edge right after the stop bit is caught.
                        state_d = S_DONE;
                        data_d  = shift_q;
                        pe_d    = par_err_q;
                        fe_d    = frm_err_q | ~vote;
                        dv_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            samp_q    <= 2'b11;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7N2) at 32 clocks per bit, scoreboard-checked.
module tb_uart_rx_cfg;

    localparam int CF  = 320000;
    localparam int BPS = 10000;
    localparam int B   = 32;
    localparam int H   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic dv_a, dv_b, dv_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, busy_a, busy_b, busy_c;

    uart_rx_cfg #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd_a), .data(data_a), .data_valid(dv_a),
        .parity_err(pe_a), .frame_err(fe_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd_b), .data(data_b), .data_valid(dv_b),
        .parity_err(pe_b), .frame_err(fe_b), .busy(busy_b));

    uart_rx_cfg #(.CLK_FREQ(CF), .UART_BPS(BPS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd_c), .data(data_c), .data_valid(dv_c),
        .parity_err(pe_c), .frame_err(fe_c), .busy(busy_c));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         line;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   rise[3];
    int   fall[3];
    int   last_edge[3];
    logic bprev[3];

    logic       dv_v[3], busy_v[3], pe_v[3], fe_v[3];
    logic [7:0] dat_v[3];

    always_comb begin
        dv_v[0] = dv_a;   dv_v[1] = dv_b;   dv_v[2] = dv_c;
        busy_v[0] = busy_a; busy_v[1] = busy_b; busy_v[2] = busy_c;
        pe_v[0] = pe_a;   pe_v[1] = pe_b;   pe_v[2] = pe_c;
        fe_v[0] = fe_a;   fe_v[1] = fe_b;   fe_v[2] = fe_c;
        dat_v[0] = data_a; dat_v[1] = data_b; dat_v[2] = {1'b0, data_c};
    end

    function automatic int flen(input int ln);
        case (ln)
            0:       return 10;
            1:       return 11;
            default: return 10;
        endcase
    endfunction

    // Scoreboard monitor: samples on the falling edge, pops one expected word per strobe.
    always @(negedge clk) begin
        exp_t e;
        int   want;
        for (int i = 0; i < 3; i++) begin
            if (busy_v[i] && !bprev[i]) begin
                rise[i] = cyc;
                checks++;
                if ((cyc - 1 - last_edge[i]) < 2 || (cyc - 1 - last_edge[i]) > 3) begin
                    failures++;
                    $display("FAIL t0_latency line=%0d got=%0d required=2..3", i, cyc - 1 - last_edge[i]);
                end
            end
            if (!busy_v[i] && bprev[i]) fall[i] = cyc;
            bprev[i] = busy_v[i];
            if (dv_v[i] === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid line=%0d data=%02h", i, dat_v[i]);
                end else begin
                    e = sbq.pop_front();
                    if (e.line != i || dat_v[i] !== e.d || pe_v[i] !== e.pe || fe_v[i] !== e.fe) begin
                        failures++;
                        $display("FAIL word line=%0d got data=%02h pe=%b fe=%b required line=%0d data=%02h pe=%b fe=%b",
                                 i, dat_v[i], pe_v[i], fe_v[i], e.line, e.d, e.pe, e.fe);
                    end
                    want = rise[i] - 1 + (flen(i) - 1) * B + H + 2;
                    checks++;
                    if (cyc != want) begin
                        failures++;
                        $display("FAIL valid_timing line=%0d got=%0d required=%0d", i, cyc, want);
                    end
                end
            end
        end
    end

    task automatic set_line(input int ln, input logic v);
        case (ln)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Called #1 after a posedge; each bit lasts exactly B cycles, optional 1-cycle glitch at cycle H.
    task automatic send_bits(input int ln, input logic [15:0] bits, input int n, input logic [15:0] gm);
        for (int i = 0; i < n; i++) begin
            set_line(ln, bits[i]);
            for (int c = 1; c < B; c++) begin
                @(posedge clk); #1;
                set_line(ln, (c == H && gm[i]) ? ~bits[i] : bits[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int ln, input logic [7:0] d, input int nd, input int pmode,
                              input int pbit_ovr, input int nstop, input logic stop_val, input logic glitch);
        logic [15:0] bits, gm;
        logic [7:0]  dm;
        logic        p, correct, pb;
        int          n;
        exp_t        e;
        bits = '1; gm = '0; n = 1; p = 1'b0;
        bits[0] = 1'b0;
        for (int k = 0; k < nd; k++) begin
            bits[n] = d[k]; gm[n] = glitch; p ^= d[k]; n++;
        end
        correct = (pmode == 1) ? ~p : p;
        pb = correct;
        if (pmode != 0) begin
            if (pbit_ovr >= 0) pb = pbit_ovr[0];
            bits[n] = pb; n++;
        end
        for (int k = 0; k < nstop; k++) begin
            bits[n] = stop_val; n++;
        end
        dm = d & 8'((1 << nd) - 1);
        e.line = ln; e.d = dm; e.pe = (pmode != 0) && (pb != correct); e.fe = ~stop_val;
        sbq.push_back(e);
        last_edge[ln] = cyc;
        send_bits(ln, bits, n, gm);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dat_v[i], dv_v[i], pe_v[i], fe_v[i], busy_v[i]} !== 12'h000) begin
                failures++;
                $display("FAIL reset_outputs line=%0d got=%03h required=000",
                         i, {dat_v[i], dv_v[i], pe_v[i], fe_v[i], busy_v[i]});
            end
        end
        rst_n = 1'b1;
        repeat (B) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, busy_b, busy_c} !== 3'b000) begin
            failures++;
            $display("FAIL idle_busy got=%b required=000", {busy_a, busy_b, busy_c});
        end
    endtask

    task automatic test_basic_8n1;
        send_frame(0, 8'h55, 8, 0, -1, 1, 1'b1, 1'b0);
        send_frame(0, 8'hA3, 8, 0, -1, 1, 1'b1, 1'b0);
        repeat (2 * B) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL basic_missing pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        checks++;
        if (data_a !== 8'hA3 || dv_a !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got data=%02h dv=%b required data=a3 dv=0", data_a, dv_a);
        end
    endtask

    task automatic test_even_parity;
        send_frame(1, 8'h07, 8, 2, -1, 1, 1'b1, 1'b0);
        send_frame(1, 8'h07, 8, 2, 0, 1, 1'b1, 1'b0);
        repeat (2 * B) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL parity_missing pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        checks++;
        if (pe_b !== 1'b1 || data_b !== 8'h07) begin
            failures++;
            $display("FAIL parity_hold got pe=%b data=%02h required pe=1 data=07", pe_b, data_b);
        end
    endtask

    task automatic test_frame_error;
        send_frame(0, 8'h3C, 8, 0, -1, 1, 1'b0, 1'b0);
        repeat (3 * B) @(posedge clk);
        #1;
        checks++;
        if (fe_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL break_state got fe=%b busy=%b required fe=1 busy=0", fe_a, busy_a);
        end
        rxd_a = 1'b1;
        repeat (B) @(posedge clk);
        #1;
        send_frame(0, 8'h81, 8, 0, -1, 1, 1'b1, 1'b0);
        repeat (2 * B) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL frame_missing pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        checks++;
        if (fe_a !== 1'b0 || data_a !== 8'h81) begin
            failures++;
            $display("FAIL frame_recover got fe=%b data=%02h required fe=0 data=81", fe_a, data_a);
        end
    endtask

    task automatic test_false_start;
        rise[0] = -1000;
        fall[0] = -1;
        @(posedge clk); #1;
        last_edge[0] = cyc;
        rxd_a = 1'b0;
        repeat (B / 4) @(posedge clk);
        #1;
        rxd_a = 1'b1;
        repeat (2 * B) @(posedge clk);
        #1;
        checks++;
        if (fall[0] - rise[0] != H + 1) begin
            failures++;
            $display("FAIL false_start_busy got=%0d required=%0d", fall[0] - rise[0], H + 1);
        end
        checks++;
        if (data_a !== 8'h81 || busy_a !== 1'b0 || sbq.size() != 0) begin
            failures++;
            $display("FAIL false_start_state got data=%02h busy=%b required data=81 busy=0", data_a, busy_a);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(2, 8'h7F, 7, 0, -1, 2, 1'b1, 1'b1);
        send_frame(2, 8'h00, 7, 0, -1, 2, 1'b1, 1'b1);
        send_frame(2, 8'h2A, 7, 0, -1, 2, 1'b1, 1'b1);
        repeat (2 * B) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL b2b_missing pending=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] part;
        part = 16'h0000;
        part[4:1] = 4'hA;
        last_edge[0] = cyc;
        send_bits(0, part, 5, 16'h0000);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_busy got=%b required=1", busy_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_a, dv_a, pe_a, fe_a, busy_a} !== 12'h000) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%03h required=000", {data_a, dv_a, pe_a, fe_a, busy_a});
        end
        rxd_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (B) @(posedge clk);
        #1;
        send_frame(0, 8'hC6, 8, 0, -1, 1, 1'b1, 1'b0);
        repeat (2 * B) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0 || data_a !== 8'hC6) begin
            failures++;
            $display("FAIL post_reset_frame got data=%02h pending=%0d required data=c6 pending=0", data_a, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            bprev[i] = 1'b0; rise[i] = 0; fall[i] = 0; last_edge[i] = 0;
        end
        test_reset();
        test_basic_8n1();
        test_even_parity();
        test_frame_error();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d required=completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
